uart_tx_fifo: RTL

Transmit-side buffer and launch sequencer sitting directly upstream of the `uart` transmitter. Accepts bytes from the host side into a synchronous FIFO and, one frame at a time, drives the transmitter's `tx_start`/`din` inputs. It releases the next byte only after the transmitter reports `tx_done_tick`. This removes the need for the host to hold `tx_start` and `din` stable per frame.

---
 rtl/uart_tx_fifo.sv | 100 ++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO and frame launcher feeding the uart transmitter.
// Buffers host bytes and launches one frame per tx_done_tick.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] w_data,
  input  logic                 tx_en,
  input  logic                 clr_ovf,
  input  logic                 tx_done_tick,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   count,
  output logic                 overflow,
  output logic                 tx_start,
  output logic [DATA_BITS-1:0] tx_din,
  output logic                 busy
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned CW    = ADDR_BITS + 1;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] wptr_q, rptr_q;
  logic [CW-1:0]        count_d;
  logic                 push, drop, pop;

  assign push    = wr & ~full;
  assign drop    = wr & full;
  assign count_d = count + CW'(push) - CW'(pop);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and pop decision; a done tick with data queued relaunches directly
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_en && !empty) begin
          pop     = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tx_done_tick) begin
          if (tx_en && !empty) pop = 1'b1;
          else                 state_d = S_IDLE;
        end
      end
    endcase
  end

  // Storage array; contents are discarded on reset through the pointers
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= w_data;
  end

  // Pointers, occupancy flags and the launch outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      tx_start <= 1'b0;
      tx_din   <= '0;
      busy     <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + ADDR_BITS'(1);
      if (pop)  rptr_q <= rptr_q + ADDR_BITS'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
      // A dropped write wins over a simultaneous clear
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      tx_start <= pop;
      if (pop) tx_din <= mem[rptr_q];
      busy <= (state_d == S_WAIT);
    end
  end

endmodule
